exec_sequencer: RTL

Multi-cycle control sequencer for the picoMIPS core. It sits beside the combinational decoder and decides, each cycle, whether the PC advances.
- Stalls load-and-stall (LDS) instructions until a debounced demoSwitch press.
- Sequences MUL/MULI through a fixed-latency multiplier.
- All other opcodes complete in one cycle.

---
 rtl/exec_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for picoMIPS: stalls LDS until a debounced
// switch press and sequences MUL/MULI through a fixed-latency multiplier.
module exec_sequencer #(
  parameter int unsigned       O_SIZE          = 3,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 4,
  parameter int unsigned       MUL_CYCLES      = 2,
  parameter logic [O_SIZE-1:0] OP_MUL          = O_SIZE'(4),
  parameter logic [O_SIZE-1:0] OP_MULI         = O_SIZE'(5),
  parameter logic [O_SIZE-1:0] OP_LDS          = O_SIZE'(6)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [O_SIZE-1:0] opCode,
  input  logic              demoSwitch,
  output logic              pcInc,
  output logic              immSwitches,
  output logic              mulStart,
  output logic              mulBusy,
  output logic              switchLevel
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MC_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDS_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [MC_W-1:0]        mul_cnt_q, mul_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic                   sw_db_q, sw_db_dly_q;
  logic                   sw_s, press;
  logic                   pc_inc, imm_sw, mul_start, mul_busy;

  assign sw_s  = sync_q[SYNC_STAGES-1];
  assign press = sw_db_q & ~sw_db_dly_q;

  // Synchroniser, debounce and edge detect for the raw push switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      sw_db_q     <= 1'b0;
      sw_db_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], demoSwitch};
      sw_db_dly_q <= sw_db_q;
      if (sw_s == sw_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        sw_db_q  <= ~sw_db_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    pc_inc    = 1'b0;
    imm_sw    = 1'b0;
    mul_start = 1'b0;
    mul_busy  = 1'b0;
    case (state_q)
      RUN: begin
        if (opCode == OP_LDS) begin
          if (press) begin
            pc_inc = 1'b1;
            imm_sw = 1'b1;
          end else begin
            state_d = LDS_WAIT;
          end
        end else if (opCode == OP_MUL || opCode == OP_MULI) begin
          mul_start = 1'b1;
          mul_cnt_d = MC_W'(MUL_CYCLES - 1);
          state_d   = MUL_WAIT;
        end else begin
          pc_inc = 1'b1;
        end
      end
      LDS_WAIT: begin
        if (press) begin
          pc_inc  = 1'b1;
          imm_sw  = 1'b1;
          state_d = RUN;
        end
      end
      MUL_WAIT: begin
        mul_busy = 1'b1;
        if (mul_cnt_q != '0) begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end else begin
          pc_inc  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Outputs are Mealy, so they are forced low while reset is held.
  assign pcInc       = pc_inc    & ~reset;
  assign immSwitches = imm_sw    & ~reset;
  assign mulStart    = mul_start & ~reset;
  assign mulBusy     = mul_busy  & ~reset;
  assign switchLevel = sw_db_q   & ~reset;

endmodule
